readout_sequencer: RTL and testbench

- Sequences counter readout after an inst_readout command.
- Walks all channels and, per channel, all counter words. Drives the load_cnt_ser one-hot and the select_reg mux code.
- Gates an 8-bit serializer with shift_en and waits for downstream backpressure between words.
- Sits between the instruction driver (start/abort pulses) and the channel counter/serializer datapath, on the iclk domain.

---
 rtl/psec5_pkg.sv | 29 ++
 rtl/readout_sequencer_if.sv | 43 ++++
 rtl/readout_sequencer.sv | 149 ++++++++++++++
 tb/tb_readout_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/psec5_pkg.sv
// ---------------------------------------------------------------------------
// psec5_pkg
// Shared constants and types for the readout sequencer. The SPI block reuses
// the channel/word constants from here.
//   NUM_CH    : number of channels (width of load_cnt_ser)
//   NUM_SEL   : counter words per channel (select_reg 0..NUM_SEL-1)
//   WORD_BITS : shift cycles per word
//   IDLE_SEL  : select_reg park code while not reading
// ---------------------------------------------------------------------------
package psec5_pkg;

   localparam int NUM_CH    = 8;
   localparam int NUM_SEL   = 7;
   localparam int WORD_BITS = 8;
   localparam logic [2:0] IDLE_SEL = 3'b111;

   localparam int CH_W      = $clog2(NUM_CH);
   localparam int SEL_W     = 3;
   localparam int BIT_CNT_W = $clog2(WORD_BITS);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT,
      WAIT,
      DONE
   } rdseq_state_t;

endpackage

// File: rtl/readout_sequencer_if.sv
// ---------------------------------------------------------------------------
// readout_sequencer_if
// Bundles the command inputs and the datapath control outputs of the
// readout sequencer.
//   start, abort  : one-cycle command pulses from the instruction driver
//   word_ready    : downstream accepted the current word (level, may stay high)
//   load_cnt_ser  : one-hot of the channel being read
//   select_reg    : word index within the channel
//   shift_en      : serializer shift strobe
//   word_done     : pulse after the last shift of a word
//   busy, done    : activity flag and completion pulse
//   state_dbg     : current sequencer state, for observation only
// Handshake: word_ready is only sampled while the sequencer sits in WAIT;
// the sequencer leaves WAIT on the first edge where word_ready is high.
// slave = the sequencer, master = whoever drives the commands.
// ---------------------------------------------------------------------------
interface readout_sequencer_if;
   import psec5_pkg::*;

   logic                start;
   logic                abort;
   logic                word_ready;
   logic [NUM_CH-1:0]   load_cnt_ser;
   logic [SEL_W-1:0]    select_reg;
   logic                shift_en;
   logic                word_done;
   logic                busy;
   logic                done;
   rdseq_state_t        state_dbg;

   modport slave (
      input  start, abort, word_ready,
      output load_cnt_ser, select_reg, shift_en, word_done, busy, done,
             state_dbg
   );

   modport master (
      output start, abort, word_ready,
      input  load_cnt_ser, select_reg, shift_en, word_done, busy, done,
             state_dbg
   );

endinterface

// File: rtl/readout_sequencer.sv
// ---------------------------------------------------------------------------
// readout_sequencer
// Walks all channels and all counter words per channel after a start pulse,
// selecting the channel (load_cnt_ser one-hot) and word (select_reg), gating
// the serializer with shift_en for WORD_BITS cycles per word, and waiting
// for word_ready between words. abort returns to idle without done.
// Ports:
//   iclk  : clock, posedge
//   rstn  : asynchronous active-low reset
//   bus   : readout_sequencer_if.slave (commands in, datapath controls out)
// All outputs are registered: the output process computes the values that
// belong to the next state, and the register process captures them on the
// same edge as the state.
// ---------------------------------------------------------------------------
module readout_sequencer
   import psec5_pkg::*;
(
   input  logic                  iclk,
   input  logic                  rstn,
   readout_sequencer_if.slave    bus
);

   rdseq_state_t           state_q, state_nxt;
   logic [CH_W-1:0]        ch_q, ch_nxt;
   logic [SEL_W-1:0]       sel_q, sel_nxt;
   logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_nxt;

   logic [NUM_CH-1:0]      load_q, load_nxt;
   logic [SEL_W-1:0]       select_q, select_nxt;
   logic                   shift_q, shift_nxt;
   logic                   wdone_q, wdone_nxt;
   logic                   busy_q, busy_nxt;
   logic                   done_q, done_nxt;

   // State, counters and output registers
   always_ff @(posedge iclk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         ch_q      <= '0;
         sel_q     <= '0;
         bit_cnt_q <= '0;
         load_q    <= '0;
         select_q  <= IDLE_SEL;
         shift_q   <= 1'b0;
         wdone_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         ch_q      <= ch_nxt;
         sel_q     <= sel_nxt;
         bit_cnt_q <= bit_cnt_nxt;
         load_q    <= load_nxt;
         select_q  <= select_nxt;
         shift_q   <= shift_nxt;
         wdone_q   <= wdone_nxt;
         busy_q    <= busy_nxt;
         done_q    <= done_nxt;
      end
   end

   // Next-state and counter logic
   always_comb begin
      state_nxt   = state_q;
      ch_nxt      = ch_q;
      sel_nxt     = sel_q;
      bit_cnt_nxt = bit_cnt_q;

      // abort from any active state (and over a simultaneous start in IDLE)
      // returns everything to its reset value.
      if (bus.abort) begin
         state_nxt   = IDLE;
         ch_nxt      = '0;
         sel_nxt     = '0;
         bit_cnt_nxt = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_nxt = LOAD;
                  ch_nxt    = '0;
                  sel_nxt   = '0;
               end
            end
            LOAD: begin
               state_nxt   = SHIFT;
               bit_cnt_nxt = '0;
            end
            SHIFT: begin
               if (bit_cnt_q == BIT_CNT_W'(WORD_BITS - 1)) begin
                  state_nxt = WAIT;
               end else begin
                  bit_cnt_nxt = bit_cnt_q + BIT_CNT_W'(1);
               end
            end
            WAIT: begin
               if (bus.word_ready) begin
                  bit_cnt_nxt = '0;
                  if (sel_q < SEL_W'(NUM_SEL - 1)) begin
                     state_nxt = SHIFT;
                     sel_nxt   = sel_q + SEL_W'(1);
                  end else if (ch_q < CH_W'(NUM_CH - 1)) begin
                     state_nxt = LOAD;
                     ch_nxt    = ch_q + CH_W'(1);
                     sel_nxt   = '0;
                  end else begin
                     state_nxt = DONE;
                     ch_nxt    = '0;
                     sel_nxt   = '0;
                  end
               end
            end
            DONE: begin
               state_nxt = IDLE;
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   // Output values belonging to the next state
   always_comb begin
      load_nxt   = '0;
      select_nxt = IDLE_SEL;
      shift_nxt  = 1'b0;
      wdone_nxt  = 1'b0;
      busy_nxt   = (state_nxt != IDLE);
      done_nxt   = (state_nxt == DONE);

      if (state_nxt == LOAD || state_nxt == SHIFT || state_nxt == WAIT) begin
         load_nxt   = {{(NUM_CH-1){1'b0}}, 1'b1} << ch_nxt;
         select_nxt = sel_nxt;
      end
      shift_nxt = (state_nxt == SHIFT);
      // word_done only on entry to WAIT, not while stalled there
      wdone_nxt = (state_nxt == WAIT) && (state_q != WAIT);
   end

   assign bus.load_cnt_ser = load_q;
   assign bus.select_reg   = select_q;
   assign bus.shift_en     = shift_q;
   assign bus.word_done    = wdone_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_readout_sequencer.sv
// ---------------------------------------------------------------------------
// tb_readout_sequencer
// Builds the expected output timeline of a whole readout from the channel /
// word / shift structure, drives word_ready from the same timeline, and
// compares the DUT outputs against it every cycle. Literal expectations pin
// the key cycle numbers.
// ---------------------------------------------------------------------------
module tb_readout_sequencer;
   import psec5_pkg::*;

   logic iclk;
   logic rstn;

   readout_sequencer_if bus ();

   readout_sequencer dut (
      .iclk (iclk),
      .rstn (rstn),
      .bus  (bus)
   );

   // ---------------- clock / reset ----------------
   initial iclk = 1'b0;
   always #5 iclk = ~iclk;

   // ---------------- scoreboard ----------------
   logic [14:0] exp_q[$];
   logic        wr_q[$];

   int vecs;
   int fails;

   int done_cycle;
   int done_seen;
   int shift_seen;
   int wdone_seen;
   logic [7:0] load_c1, load_c65, load_c449;
   logic [2:0] sel_c1;

   function automatic logic [14:0] pk(input logic [7:0] l, input logic [2:0] s,
                                      input logic sh, input logic wd,
                                      input logic b, input logic d);
      return {l, s, sh, wd, b, d};
   endfunction

   function automatic logic [14:0] idle_vec();
      return pk(8'd0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
   endfunction

   function automatic logic [14:0] act_vec();
      return {bus.load_cnt_ser, bus.select_reg, bus.shift_en, bus.word_done,
              bus.busy, bus.done};
   endfunction

   task automatic check_vec(input string name, input int idx,
                            input logic [14:0] act, input logic [14:0] exp);
      vecs++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s[%0d] got=%h exp=%h", name, idx, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      vecs++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s got=%0d exp=%0d", name, act, exp);
      end
   endtask

   // mode 0: no stalls, 1: random 0..3 stall cycles per word,
   // 2: five stall cycles after the first word only
   task automatic build(input int mode);
      exp_q.delete();
      wr_q.delete();
      for (int c = 0; c < NUM_CH; c++) begin
         logic [7:0] oh;
         oh = 8'd1 << c;
         exp_q.push_back(pk(oh, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0));
         wr_q.push_back(1'($urandom_range(0, 1)));
         for (int s = 0; s < NUM_SEL; s++) begin
            int k;
            for (int b = 0; b < WORD_BITS; b++) begin
               exp_q.push_back(pk(oh, 3'(s), 1'b1, 1'b0, 1'b1, 1'b0));
               wr_q.push_back(1'($urandom_range(0, 1)));
            end
            if (mode == 1)                         k = int'($urandom_range(0, 3));
            else if (mode == 2 && c == 0 && s == 0) k = 5;
            else                                   k = 0;
            for (int j = 0; j <= k; j++) begin
               exp_q.push_back(pk(oh, 3'(s), 1'b0, (j == 0), 1'b1, 1'b0));
               wr_q.push_back(j == k);
            end
         end
      end
      exp_q.push_back(pk(8'd0, 3'b111, 1'b0, 1'b0, 1'b1, 1'b1));
      wr_q.push_back(1'($urandom_range(0, 1)));
   endtask

   // Runs the built timeline. Called at a negedge with the DUT idle.
   // abort_at / reset_at / busy_start_at are timeline indices (-1 = unused).
   task automatic run(input int abort_at, input int busy_start_at, input int reset_at);
      done_cycle = -1;
      done_seen  = 0;
      shift_seen = 0;
      wdone_seen = 0;
      check_vec("pre_start_idle", 0, act_vec(), idle_vec());
      bus.start      = 1'b1;
      bus.abort      = 1'b0;
      bus.word_ready = 1'($urandom_range(0, 1));
      @(posedge iclk);
      @(negedge iclk);
      bus.start = 1'b0;
      for (int idx = 0; idx < exp_q.size(); idx++) begin
         logic [14:0] a;
         a = act_vec();
         check_vec("cycle", idx + 1, a, exp_q[idx]);
         if (bus.done) begin
            done_seen++;
            if (done_cycle < 0) done_cycle = idx + 1;
         end
         if (bus.shift_en)  shift_seen++;
         if (bus.word_done) wdone_seen++;
         if (idx + 1 == 1)   begin load_c1 = bus.load_cnt_ser; sel_c1 = bus.select_reg; end
         if (idx + 1 == 65)  load_c65  = bus.load_cnt_ser;
         if (idx + 1 == 449) load_c449 = bus.load_cnt_ser;
         if (idx == abort_at) begin
            bus.abort      = 1'b1;
            bus.word_ready = 1'b1;
            @(posedge iclk);
            @(negedge iclk);
            bus.abort = 1'b0;
            check_vec("after_abort", idx + 2, act_vec(), idle_vec());
            if (bus.done) done_seen++;
            @(posedge iclk);
            @(negedge iclk);
            check_vec("after_abort_idle", idx + 3, act_vec(), idle_vec());
            if (bus.done) done_seen++;
            return;
         end
         if (idx == reset_at) begin
            #1 rstn = 1'b0;
            #1;
            check_vec("async_reset", idx + 1, act_vec(), idle_vec());
            @(posedge iclk);
            @(negedge iclk);
            check_vec("in_reset", idx + 2, act_vec(), idle_vec());
            if (bus.done) done_seen++;
            rstn = 1'b1;
            @(posedge iclk);
            @(negedge iclk);
            check_vec("after_reset", idx + 3, act_vec(), idle_vec());
            if (bus.done) done_seen++;
            return;
         end
         bus.word_ready = wr_q[idx];
         bus.start      = (idx == busy_start_at);
         @(posedge iclk);
         @(negedge iclk);
         bus.start = 1'b0;
      end
      check_vec("post_done_idle", exp_q.size() + 1, act_vec(), idle_vec());
   endtask

   // ---------------- main sequence ----------------
   initial begin
      vecs  = 0;
      fails = 0;
      rstn           = 1'b0;
      bus.start      = 1'b0;
      bus.abort      = 1'b0;
      bus.word_ready = 1'b0;
      repeat (3) @(negedge iclk);
      check_vec("reset_values", 0, act_vec(), idle_vec());
      check_int("reset_state_idle", int'(bus.state_dbg == IDLE), 1);
      rstn = 1'b1;
      @(negedge iclk);

      // Full readout, no stalls
      build(0);
      run(-1, -1, -1);
      check_int("t1_done_cycle", done_cycle, 513);
      check_int("t1_shift_cycles", shift_seen, 448);
      check_int("t1_word_done_count", wdone_seen, 56);
      check_int("t1_load_c1", int'(load_c1), 8'h01);
      check_int("t1_sel_c1", int'(sel_c1), 0);
      check_int("t1_load_c65", int'(load_c65), 8'h02);
      check_int("t1_load_c449", int'(load_c449), 8'h80);

      // Backpressure on the first word
      build(2);
      run(-1, -1, -1);
      check_int("t3_done_cycle", done_cycle, 518);

      // Abort during SHIFT of ch 3, sel 4, then a fresh readout
      build(0);
      run(3 * 64 + 1 + 4 * 9 + 3, -1, -1);
      check_int("t4_no_done", done_seen, 0);
      build(0);
      run(-1, -1, -1);
      check_int("t4_restart_load_c1", int'(load_c1), 8'h01);
      check_int("t4_restart_done_cycle", done_cycle, 513);

      // start while busy is ignored
      build(0);
      run(-1, 99, -1);
      check_int("t5_done_cycle", done_cycle, 513);

      // start and abort together while idle
      bus.start = 1'b1;
      bus.abort = 1'b1;
      @(posedge iclk);
      @(negedge iclk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      check_vec("t5_start_abort_idle", 0, act_vec(), idle_vec());
      @(posedge iclk);
      @(negedge iclk);
      check_vec("t5_start_abort_idle2", 0, act_vec(), idle_vec());

      // Async reset while in WAIT, then a full readout
      build(1);
      begin
         int w;
         int cnt;
         w = -1;
         cnt = 0;
         for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i][2] && w < 0) begin
               cnt++;
               if (cnt == 10) w = i;
            end
         end
         run(-1, -1, w);
      end
      check_int("t6_no_done", done_seen, 0);
      build(0);
      run(-1, -1, -1);
      check_int("t6_done_cycle", done_cycle, 513);

      // Random stalls and random ignored inputs
      for (int r = 0; r < 3; r++) begin
         build(1);
         run(-1, int'($urandom_range(0, 400)), -1);
         check_int("rand_done_count", done_seen, 1);
         check_int("rand_word_done_count", wdone_seen, 56);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule
